cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 49 ++++
 rtl/cpu_ctrl_dec3to8.sv | 13 +
 rtl/cpu_ctrl.sv | 132 +++++++++++++
 tb/tb_cpu_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, state encoding, IR field positions and ALU codes for cpu_ctrl.
// CPU_CTRL_AND_EN enables the optional "and" instruction (opcode 100).
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    StT0 = 2'd0,
    StT1 = 2'd1,
    StT2 = 2'd2,
    StT3 = 2'd3
  } state_e;

  localparam logic [2:0] OpMv  = 3'b000;
  localparam logic [2:0] OpMvi = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;

  localparam int unsigned OpcodeMsb = 15;
  localparam int unsigned OpcodeLsb = 13;
  localparam int unsigned RxMsb     = 12;
  localparam int unsigned RxLsb     = 10;
  localparam int unsigned RyMsb     = 9;
  localparam int unsigned RyLsb     = 7;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;

  // Opcodes that run the three-step A/G datapath sequence.
  function automatic logic is_alu_op(logic [2:0] op);
    logic res;
    res = (op == OpAdd) || (op == OpSub);
`ifdef CPU_CTRL_AND_EN
    res = res || (op == OpAnd);
`endif
    return res;
  endfunction

  function automatic logic [1:0] alu_code(logic [2:0] op);
    logic [1:0] code;
    code = AluAdd;
    if (op == OpSub) code = AluSub;
`ifdef CPU_CTRL_AND_EN
    if (op == OpAnd) code = AluAnd;
`endif
    return code;
  endfunction

endpackage

// File: rtl/cpu_ctrl_dec3to8.sv
// 3-bit to one-hot-8 decoder with enable; drives register enables in cpu_ctrl.
module dec3to8 (
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic [7:0] dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) dec_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Four-state (T0..T3) control sequencer for a simple bus-based CPU datapath.
// Defining CPU_CTRL_AND_EN turns opcode 100 into "and"; otherwise it is a NOP.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instr,
  output logic        ir_load,
  output logic [7:0]  r_in,
  output logic [7:0]  r_out,
  output logic        din_out,
  output logic        g_out,
  output logic        a_in,
  output logic        g_in,
  output logic [1:0]  alu_op,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  logic [15:0] ir_q;

  logic [2:0] op, rx, ry;
  logic       rin_en, rout_en;
  logic [2:0] rout_sel;
  logic       unused_ir;

  assign op        = ir_q[OpcodeMsb:OpcodeLsb];
  assign rx        = ir_q[RxMsb:RxLsb];
  assign ry        = ir_q[RyMsb:RyLsb];
  assign unused_ir = ^ir_q[6:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StT0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= instr;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_load  = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = rx;
    din_out  = 1'b0;
    g_out    = 1'b0;
    a_in     = 1'b0;
    g_in     = 1'b0;
    alu_op   = AluAdd;
    done     = 1'b0;
    unique case (state_q)
      StT0: begin
        if (run) begin
          ir_load = 1'b1;
          state_d = StT1;
        end
      end
      StT1: begin
        state_d = StT0;
        case (op)
          OpMv: begin
            rout_en  = 1'b1;
            rout_sel = ry;
            rin_en   = 1'b1;
            done     = 1'b1;
          end
          OpMvi: begin
            din_out = 1'b1;
            rin_en  = 1'b1;
            done    = 1'b1;
          end
          default: begin
            if (is_alu_op(op)) begin
              rout_en = 1'b1;
              a_in    = 1'b1;
              state_d = StT2;
            end else begin
              done = 1'b1;
            end
          end
        endcase
      end
      StT2: begin
        rout_en  = 1'b1;
        rout_sel = ry;
        g_in     = 1'b1;
        alu_op   = alu_code(op);
        state_d  = StT3;
      end
      StT3: begin
        g_out   = 1'b1;
        rin_en  = 1'b1;
        done    = 1'b1;
        state_d = StT0;
      end
      default: state_d = StT0;
    endcase
    // Reset is synchronous, so the decoded outputs must be squashed explicitly.
    if (reset) begin
      ir_load = 1'b0;
      rin_en  = 1'b0;
      rout_en = 1'b0;
      din_out = 1'b0;
      g_out   = 1'b0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      alu_op  = AluAdd;
      done    = 1'b0;
    end
  end

  assign busy = (state_q != StT0) && !reset;

  dec3to8 u_dec_rin (
    .en_i  (rin_en),
    .sel_i (rx),
    .dec_o (r_in)
  );

  dec3to8 u_dec_rout (
    .en_i  (rout_en),
    .sel_i (rout_sel),
    .dec_o (r_out)
  );

endmodule

// File: tb/tb_cpu_ctrl.sv
// Randomized self-checking bench for cpu_ctrl against a per-instruction step-table model.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [15:0] instr = '0;
  logic        ir_load, din_out, g_out, a_in, g_in, busy, done;
  logic [7:0]  r_in, r_out;
  logic [1:0]  alu_op;

`ifdef CPU_CTRL_AND_EN
  localparam bit AndEn = 1'b1;
`else
  localparam bit AndEn = 1'b0;
`endif

  cpu_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .instr   (instr),
    .ir_load (ir_load),
    .r_in    (r_in),
    .r_out   (r_out),
    .din_out (din_out),
    .g_out   (g_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .alu_op  (alu_op),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  logic [24:0] dut_vec;
  assign dut_vec = {ir_load, r_in, r_out, din_out, g_out, a_in, g_in, alu_op, busy, done};

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [24:0] mk(input logic irl, input logic [7:0] rin,
                                     input logic [7:0] rout, input logic din, input logic g,
                                     input logic a, input logic gin, input logic [1:0] alu,
                                     input logic bsy, input logic dn);
    return {irl, rin, rout, din, g, a, gin, alu, bsy, dn};
  endfunction

  // Expected outputs for each cycle after T0, straight from the instruction table.
  logic [24:0] exp_q[$];

  function automatic void model(input logic [15:0] ins);
    logic [2:0] op;
    logic [7:0] orx, ory;
    bit         alu_seq;
    logic [1:0] code;
    op   = ins[15:13];
    orx  = 8'd1 << ins[12:10];
    ory  = 8'd1 << ins[9:7];
    code = (op == 3'd3) ? 2'b01 : (op == 3'd4) ? 2'b10 : 2'b00;
    alu_seq = (op == 3'd2) || (op == 3'd3) || (AndEn && op == 3'd4);
    exp_q.delete();
    if (op == 3'd0) begin
      exp_q.push_back(mk(0, orx, ory, 0, 0, 0, 0, 2'b00, 1, 1));
    end else if (op == 3'd1) begin
      exp_q.push_back(mk(0, orx, 8'h00, 1, 0, 0, 0, 2'b00, 1, 1));
    end else if (alu_seq) begin
      exp_q.push_back(mk(0, 8'h00, orx, 0, 0, 1, 0, 2'b00, 1, 0));
      exp_q.push_back(mk(0, 8'h00, ory, 0, 0, 0, 1, code, 1, 0));
      exp_q.push_back(mk(0, orx, 8'h00, 0, 1, 0, 0, 2'b00, 1, 1));
    end else begin
      exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 1));
    end
  endfunction

  // Issue one instruction from T0; abort_at=k asserts reset in step k (0 = no abort).
  task automatic run_instr(input logic [15:0] ins, input bit toggle, input int abort_at);
    @(posedge clk); #1;
    run   = 1'b1;
    instr = ins;
    model(ins);
    @(negedge clk);
    chk($sformatf("ir_load_%h", ins), 32'(dut_vec), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      run   = toggle ? 1'($urandom) : 1'b0;
      instr = 16'($urandom);
      if (abort_at == i + 1) begin
        reset = 1'b1;
        @(negedge clk);
        chk($sformatf("abort_outs_%h_t%0d", ins, i + 1), 32'(dut_vec), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        chk($sformatf("abort_idle_%h", ins), 32'(dut_vec), 32'd0);
        return;
      end
      @(negedge clk);
      chk($sformatf("step_%h_t%0d", ins, i + 1), 32'(dut_vec), 32'(exp_q[i]));
    end
    @(posedge clk); #1;
    run = 1'b0;
    @(negedge clk);
    chk($sformatf("back_t0_%h", ins), 32'(dut_vec), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0)
      chk("bus_excl", 32'($countones({r_out, din_out, g_out}) <= 1), 32'd1);
  end

  initial begin
    int abort_at;
    reset = 1'b1;
    run   = 1'b1;
    instr = 16'h3C00;
    @(negedge clk);
    chk("rst_outs", 32'(dut_vec), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_outs2", 32'(dut_vec), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    chk("rst_idle", 32'(dut_vec), 32'd0);

    run_instr(16'h3C00, 1'b0, 0);
    run_instr(16'h4500, 1'b0, 0);
    run_instr(16'h6E00, 1'b0, 0);
    run_instr(16'h0280, 1'b1, 0);
    run_instr(16'h4500, 1'b0, 2);
    run_instr(16'h4500, 1'b1, 0);
    run_instr(16'h8000, 1'b0, 0);

    for (int n = 0; n < 250; n++) begin
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(16'($urandom), 1'($urandom), abort_at);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        @(posedge clk); #1;
        run   = 1'b0;
        instr = 16'($urandom);
        @(negedge clk);
        chk("idle", 32'(dut_vec), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
